cnn_seq_ctrl: RTL

CNN_SEQ_CTRL -- requirements
Module: cnn_seq_ctrl

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/cnn_stage_cnt.sv | 27 ++
 rtl/cnn_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN layer sequencer.
// Holds the state encoding and the default stage lengths.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_L3,
    S_POOL,
    S_DONE
  } state_t;

  localparam int DEF_L1      = 4;
  localparam int DEF_L2      = 8;
  localparam int DEF_L3      = 16;
  localparam int DEF_POOL_TO = 64;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cnn_stage_cnt.sv
// Loadable down-counter shared by all timed stages.
// Saturates at zero and flags it.
module cnn_stage_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Frame sequencer for a three-layer CNN with pooled output.
// Steps L1 -> L2 -> L3 -> POOL -> DONE per accepted picture.
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int L1_CYCLES    = DEF_L1,
  parameter int L2_CYCLES    = DEF_L2,
  parameter int L3_CYCLES    = DEF_L3,
  parameter int POOL_TIMEOUT = DEF_POOL_TO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pic_valid,
  input  logic [255:0] i_pic_data,
  output logic         o_pic_ready,
  output logic [255:0] o_pic_data,
  output logic         o_l1_en,
  output logic         o_l2_en,
  output logic         o_l3_en,
  output logic [1:0]   o_weight_sel,
  input  logic         i_l3p_valid,
  input  logic         i_abort,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [15:0]  o_frame_cnt
);

  localparam int CMAX = max4(L1_CYCLES, L2_CYCLES,
                             L3_CYCLES, POOL_TIMEOUT);
  localparam int CW   = $clog2(CMAX) + 1;

  state_t        state;
  state_t        nxt;
  logic          err_nxt;
  logic          hs;
  logic          load;
  logic [CW-1:0] load_val;
  logic          cnt_zero;

  // Ready is gated by reset so every output reads 0 while held.
  assign o_pic_ready = rst_n & (state == S_IDLE) & ~i_abort;
  assign hs          = o_pic_ready & i_pic_valid;

  always_comb begin
    nxt     = state;
    err_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hs) nxt = S_L1;
      end
      S_L1: begin
        if (i_abort)       nxt = S_IDLE;
        else if (cnt_zero) nxt = S_L2;
      end
      S_L2: begin
        if (i_abort)       nxt = S_IDLE;
        else if (cnt_zero) nxt = S_L3;
      end
      S_L3: begin
        if (i_abort)       nxt = S_IDLE;
        else if (cnt_zero) nxt = S_POOL;
      end
      S_POOL: begin
        if (i_abort) begin
          nxt = S_IDLE;
        end else if (i_l3p_valid) begin
          nxt = S_DONE;
        end else if (cnt_zero) begin
          nxt     = S_DONE;
          err_nxt = 1'b1;
        end
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // Reload the shared counter on entry to each timed stage.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    if (nxt != state) begin
      unique case (1'b1)
        (nxt == S_L1): begin
          load     = 1'b1;
          load_val = CW'(L1_CYCLES - 1);
        end
        (nxt == S_L2): begin
          load     = 1'b1;
          load_val = CW'(L2_CYCLES - 1);
        end
        (nxt == S_L3): begin
          load     = 1'b1;
          load_val = CW'(L3_CYCLES - 1);
        end
        (nxt == S_POOL): begin
          load     = 1'b1;
          load_val = CW'(POOL_TIMEOUT - 1);
        end
        default: begin
          load = 1'b0;
        end
      endcase
    end
  end

  cnn_stage_cnt #(
    .W(CW)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      o_pic_data   <= '0;
      o_l1_en      <= 1'b0;
      o_l2_en      <= 1'b0;
      o_l3_en      <= 1'b0;
      o_weight_sel <= 2'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_frame_cnt  <= 16'd0;
    end else begin
      state   <= nxt;
      o_l1_en <= (nxt == S_L1);
      o_l2_en <= (nxt == S_L2);
      o_l3_en <= (nxt == S_L3);
      o_busy  <= (nxt != S_IDLE);
      o_done  <= (nxt == S_DONE);
      o_err   <= (nxt == S_DONE) & err_nxt;
      unique case (nxt)
        S_L1:    o_weight_sel <= 2'd1;
        S_L2:    o_weight_sel <= 2'd2;
        S_L3:    o_weight_sel <= 2'd3;
        default: o_weight_sel <= 2'd0;
      endcase
      if (hs) o_pic_data <= i_pic_data;
      if (nxt == S_DONE) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule
